// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: the priority-resolved per-edge action
// applied uniformly to every stage of a pipe_reg_chain.
package pipe_pkg;

    localparam int PIPE_DEFAULT_W = 32;

    typedef enum logic [1:0] {
        PIPE_ADV,
        PIPE_HOLD,
        PIPE_KILL
    } pipe_ctl_e;

    // flush dominates stall; with neither asserted the chain advances
    function automatic pipe_ctl_e pipe_ctl(input logic stall, input logic flush);
        if (flush) return PIPE_KILL;
        if (stall) return PIPE_HOLD;
        return PIPE_ADV;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: data and valid registers updated by the shared control
// action (advance loads upstream, hold keeps, kill clears valid only).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_DEFAULT_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  pipe_ctl_e        ctl,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        case (ctl)
            PIPE_ADV: begin
                data_d  = d;
                valid_d = d_valid;
            end
            PIPE_KILL: valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q       = data_q;
    assign q_valid = valid_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage pipeline register with stall/flush, valid-stage popcount and
// optional saturating perf counters (enabled by PIPE_REG_CHAIN_PERF_EN).
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH        = PIPE_DEFAULT_W,
    parameter int               DEPTH        = 1,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter int               ZERO_INVALID = 0,
    parameter int               CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [$clog2(DEPTH+1)-1:0] occ
`ifdef PIPE_REG_CHAIN_PERF_EN
    ,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    if (WIDTH < 1 || DEPTH < 1 || CNT_W < 1) begin : g_param_chk
        $error("pipe_reg_chain: WIDTH, DEPTH and CNT_W must all be >= 1");
    end

    pipe_ctl_e ctl;
    assign ctl = pipe_ctl(stall, flush);

    // index 0 is the chain input; index i is the output of stage i-1
    logic [DEPTH:0][WIDTH-1:0] data_chain;
    logic [DEPTH:0]            vld_chain;

    assign data_chain[0] = d;
    assign vld_chain[0]  = d_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pipe_stage_reg #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .ctl     (ctl),
            .d       (data_chain[i]),
            .d_valid (vld_chain[i]),
            .q       (data_chain[i+1]),
            .q_valid (vld_chain[i+1])
        );
    end

    always_comb begin
        occ = '0;
        for (int i = 1; i <= DEPTH; i++) occ = occ + OCC_W'(vld_chain[i]);
    end

    assign q_valid = vld_chain[DEPTH];
    assign q       = (ZERO_INVALID != 0 && !vld_chain[DEPTH]) ? '0 : data_chain[DEPTH];

`ifdef PIPE_REG_CHAIN_PERF_EN
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    // both counters saturate rather than wrap
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ctl == PIPE_HOLD && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ctl == PIPE_KILL && flush_cnt_q != {CNT_W{1'b1}})
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomised bench for pipe_reg_chain: three configurations share one stimulus
// stream and are compared every edge against an array-based reference model.
module tb_pipe_reg_chain;

    localparam int         DEP[3] = '{3, 2, 1};
    localparam bit         ZI[3]  = '{1'b0, 1'b1, 1'b0};
    localparam logic [31:0] RV[3] = '{32'hDEAD_BEEF, 32'h0000_00A5, 32'hC0DE_0001};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] d = '0;
    logic        d_valid = 1'b0;

    logic [31:0] q_a, q_b, q_c;
    logic        qv_a, qv_b, qv_c;
    logic [1:0]  occ_a, occ_b;
    logic [0:0]  occ_c;
`ifdef PIPE_REG_CHAIN_PERF_EN
    logic [1:0]  sc_a, fc_a, sc_b, fc_b, sc_c, fc_c;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'hDEAD_BEEF), .ZERO_INVALID(0), .CNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q_a), .q_valid(qv_a), .occ(occ_a)
`ifdef PIPE_REG_CHAIN_PERF_EN
        , .stall_cnt(sc_a), .flush_cnt(fc_a)
`endif
    );

    pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0000_00A5), .ZERO_INVALID(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q_b), .q_valid(qv_b), .occ(occ_b)
`ifdef PIPE_REG_CHAIN_PERF_EN
        , .stall_cnt(sc_b), .flush_cnt(fc_b)
`endif
    );

    pipe_reg_chain #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'hC0DE_0001), .ZERO_INVALID(0), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q_c), .q_valid(qv_c), .occ(occ_c)
`ifdef PIPE_REG_CHAIN_PERF_EN
        , .stall_cnt(sc_c), .flush_cnt(fc_c)
`endif
    );

    logic [31:0] qo[3];
    logic        qvo[3];
    logic [7:0]  oco[3];
    always_comb begin
        qo[0] = q_a;  qo[1] = q_b;  qo[2] = q_c;
        qvo[0] = qv_a; qvo[1] = qv_b; qvo[2] = qv_c;
        oco[0] = 8'(occ_a); oco[1] = 8'(occ_b); oco[2] = 8'(occ_c);
    end

    // reference model: slot 0 is the newest entry, slot DEP-1 is visible on q
    logic [31:0] md[3][3];
    logic        mv[3][3];
    int          m_sc, m_fc;

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 3; i++) begin
                md[k][i] = RV[k];
                mv[k][i] = 1'b0;
            end
        m_sc = 0;
        m_fc = 0;
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (flush) begin
                for (int i = 0; i < 3; i++) mv[k][i] = 1'b0;
            end else if (!stall) begin
                for (int i = 2; i > 0; i--) begin
                    md[k][i] = md[k][i-1];
                    mv[k][i] = mv[k][i-1];
                end
                md[k][0] = d;
                mv[k][0] = d_valid;
            end
        end
        if (flush) begin
            if (m_fc < 3) m_fc++;
        end else if (stall) begin
            if (m_sc < 3) m_sc++;
        end
    endtask

    function automatic logic [31:0] exp_q(int k);
        if (ZI[k] && !mv[k][DEP[k]-1]) return 32'h0;
        return md[k][DEP[k]-1];
    endfunction

    function automatic logic [7:0] exp_occ(int k);
        int n = 0;
        for (int i = 0; i < DEP[k]; i++) n += int'(mv[k][i]);
        return 8'(n);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (qo[k] !== exp_q(k) || qvo[k] !== 1'b0 || oco[k] !== 8'd0) begin
                failures++;
                $display("FAIL reset_init dut%0d: got q=%h qv=%b occ=%0d, want q=%h qv=0 occ=0",
                         k, qo[k], qvo[k], oco[k], exp_q(k));
            end
        end
        // fill with valid data, then reset asynchronously mid-cycle while stalled
        for (int n = 0; n < 3; n++) begin
            d = $urandom; d_valid = 1'b1;
            tick();
        end
        stall = 1'b1;
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (q_a !== 32'hDEAD_BEEF || qv_a !== 1'b0 || occ_a !== 2'd0) begin
            failures++;
            $display("FAIL reset_async: got q=%h qv=%b occ=%0d, want q=deadbeef qv=0 occ=0", q_a, qv_a, occ_a);
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (qo[k] !== exp_q(k) || qvo[k] !== 1'b0 || oco[k] !== 8'd0) begin
                failures++;
                $display("FAIL reset_async dut%0d: got q=%h qv=%b occ=%0d, want q=%h qv=0 occ=0",
                         k, qo[k], qvo[k], oco[k], exp_q(k));
            end
        end
        #2 reset = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_latency();
        logic [31:0] seq[6] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                                32'h4444_4444, 32'h5555_5555, 32'h6666_6666};
        for (int n = 0; n < 6; n++) begin
            d = seq[n]; d_valid = 1'b1;
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (qo[k] !== exp_q(k) || qvo[k] !== mv[k][DEP[k]-1] || oco[k] !== exp_occ(k)) begin
                    failures++;
                    $display("FAIL latency dut%0d edge%0d: got q=%h qv=%b occ=%0d, want q=%h qv=%b occ=%0d",
                             k, n, qo[k], qvo[k], oco[k], exp_q(k), mv[k][DEP[k]-1], exp_occ(k));
                end
            end
            if (n >= 2) begin
                checks++;
                if (q_a !== seq[n-2] || qv_a !== 1'b1 || occ_a !== 2'd3) begin
                    failures++;
                    $display("FAIL latency_depth3 edge%0d: got q=%h qv=%b occ=%0d, want q=%h qv=1 occ=3",
                             n, q_a, qv_a, occ_a, seq[n-2]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held = q_a;
        stall = 1'b1; d = 32'hAAAA_AAAA; d_valid = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++;
            if (q_a !== held || qv_a !== 1'b1 || occ_a !== 2'd3) begin
                failures++;
                $display("FAIL stall_hold edge%0d: got q=%h qv=%b occ=%0d, want q=%h qv=1 occ=3",
                         n, q_a, qv_a, occ_a, held);
            end
        end
        stall = 1'b0;
        for (int n = 0; n < 4; n++) begin
            d = 32'h7000_0000 + 32'(n); d_valid = 1'b1;
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (qo[k] !== exp_q(k) || qvo[k] !== mv[k][DEP[k]-1] || oco[k] !== exp_occ(k)
                    || qo[k] === 32'hAAAA_AAAA) begin
                    failures++;
                    $display("FAIL stall_resume dut%0d edge%0d: got q=%h qv=%b occ=%0d, want q=%h qv=%b occ=%0d",
                             k, n, qo[k], qvo[k], oco[k], exp_q(k), mv[k][DEP[k]-1], exp_occ(k));
                end
            end
        end
    endtask

    task automatic test_flush_vs_stall();
        logic [31:0] held = q_a;
        flush = 1'b1; stall = 1'b1; d = 32'hBBBB_BBBB; d_valid = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        checks++;
        if (q_a !== held || qv_a !== 1'b0 || occ_a !== 2'd0) begin
            failures++;
            $display("FAIL flush_depth3: got q=%h qv=%b occ=%0d, want q=%h qv=0 occ=0", q_a, qv_a, occ_a, held);
        end
        checks++;
        if (q_b !== 32'h0 || qv_b !== 1'b0 || occ_b !== 2'd0) begin
            failures++;
            $display("FAIL flush_zero_invalid: got q=%h qv=%b occ=%0d, want q=0 qv=0 occ=0", q_b, qv_b, occ_b);
        end
        checks++;
        if (qv_c !== 1'b0 || occ_c !== 1'd0 || q_c !== exp_q(2)) begin
            failures++;
            $display("FAIL flush_depth1: got q=%h qv=%b occ=%0d, want q=%h qv=0 occ=0", q_c, qv_c, occ_c, exp_q(2));
        end
    endtask

    task automatic test_bubble();
        d = 32'h1010_1010; d_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            d = $urandom; d_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (qo[k] !== exp_q(k) || qvo[k] !== mv[k][DEP[k]-1] || oco[k] !== exp_occ(k)) begin
                    failures++;
                    $display("FAIL bubble dut%0d edge%0d: got q=%h qv=%b occ=%0d, want q=%h qv=%b occ=%0d",
                             k, n, qo[k], qvo[k], oco[k], exp_q(k), mv[k][DEP[k]-1], exp_occ(k));
                end
            end
        end
        checks++;
        if (q_a !== 32'h1010_1010 || qv_a !== 1'b0) begin
            failures++;
            $display("FAIL bubble_data: got q=%h qv=%b, want q=10101010 qv=0", q_a, qv_a);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            d       = $urandom;
            d_valid = ($urandom_range(0, 3) != 0);
            stall   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 15) == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (qo[k] !== exp_q(k) || qvo[k] !== mv[k][DEP[k]-1] || oco[k] !== exp_occ(k)) begin
                    failures++;
                    $display("FAIL random dut%0d cyc%0d: got q=%h qv=%b occ=%0d, want q=%h qv=%b occ=%0d",
                             k, n, qo[k], qvo[k], oco[k], exp_q(k), mv[k][DEP[k]-1], exp_occ(k));
                end
            end
`ifdef PIPE_REG_CHAIN_PERF_EN
            checks++;
            if (sc_a !== 2'(m_sc) || fc_a !== 2'(m_fc) || sc_c !== 2'(m_sc) || fc_b !== 2'(m_fc)) begin
                failures++;
                $display("FAIL random_perf cyc%0d: got stall_cnt=%0d flush_cnt=%0d, want %0d %0d",
                         n, sc_a, fc_a, m_sc, m_fc);
            end
`endif
        end
        stall = 1'b0; flush = 1'b0;
    endtask

`ifdef PIPE_REG_CHAIN_PERF_EN
    task automatic test_perf();
        #2 reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        stall = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        checks++;
        if (sc_a !== 2'd3 || fc_a !== 2'd1 || sc_b !== 2'd3 || fc_c !== 2'd1) begin
            failures++;
            $display("FAIL perf_saturate: got stall_cnt=%0d flush_cnt=%0d, want 3 1", sc_a, fc_a);
        end
    endtask
`endif

    initial begin
        model_reset();
        #12 reset = 1'b0;
        test_reset();
        test_latency();
        test_stall();
        test_flush_vs_stall();
        test_bubble();
        test_random();
`ifdef PIPE_REG_CHAIN_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
